// File: rtl/extractor_decenas_pkg.sv
// Shared constants and state encoding for the tens-digit extractor.
// Optional range check is enabled with the DEC_RANGO_CHK_EN macro.
package extractor_decenas_pkg;

    localparam logic [7:0] DIEZ            = 8'd10;
    localparam logic [7:0] MAX_DOS_DIGITOS = 8'd99;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESTA = 2'd1,
        FIN   = 2'd2
    } estado_t;

endpackage

// File: rtl/extractor_decenas_restador.sv
// Plain unsigned subtractor used for the per-iteration resto - DIEZ step.
module Restador8bits #(
    parameter int ANCHO = 8
) (
    input  logic [ANCHO-1:0] IN1,
    input  logic [ANCHO-1:0] IN2,
    output logic [ANCHO-1:0] OUT
);

    assign OUT = IN1 - IN2;

endmodule

// File: rtl/extractor_decenas.sv
// Sequential tens extractor: counts how many times DIVISOR fits in the captured value.
// Define DEC_RANGO_CHK_EN to reject inputs above 99 and expose err_rango.
module extractor_decenas
    import extractor_decenas_pkg::*;
#(
    parameter int ANCHO   = 8,
    parameter int DIVISOR = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ANCHO-1:0] in_valor,
    output logic             busy,
    output logic             done,
    output logic [ANCHO-1:0] decenas,
`ifdef DEC_RANGO_CHK_EN
    output logic             err_rango,
`endif
    output logic [ANCHO-1:0] valor_orig
);

    localparam logic [ANCHO-1:0] DIV_W = ANCHO'(DIVISOR);

    estado_t          estado_q, estado_d;
    logic [ANCHO-1:0] resto_q, resto_d;
    logic [ANCHO-1:0] cnt_q, cnt_d;
    logic [ANCHO-1:0] valor_lat_q, valor_lat_d;
    logic [ANCHO-1:0] decenas_q, decenas_d;
    logic [ANCHO-1:0] valor_orig_q, valor_orig_d;
    logic [ANCHO-1:0] resto_menos;

    Restador8bits #(.ANCHO(ANCHO)) u_restador (
        .IN1 (resto_q),
        .IN2 (DIV_W),
        .OUT (resto_menos)
    );

`ifdef DEC_RANGO_CHK_EN
    logic err_q, err_d;
    logic err_pend_q, err_pend_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_pend_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign err_rango = err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q     <= IDLE;
            resto_q      <= '0;
            cnt_q        <= '0;
            valor_lat_q  <= '0;
            decenas_q    <= '0;
            valor_orig_q <= '0;
        end else begin
            estado_q     <= estado_d;
            resto_q      <= resto_d;
            cnt_q        <= cnt_d;
            valor_lat_q  <= valor_lat_d;
            decenas_q    <= decenas_d;
            valor_orig_q <= valor_orig_d;
        end
    end

    always_comb begin
        estado_d     = estado_q;
        resto_d      = resto_q;
        cnt_d        = cnt_q;
        valor_lat_d  = valor_lat_q;
        decenas_d    = decenas_q;
        valor_orig_d = valor_orig_q;
`ifdef DEC_RANGO_CHK_EN
        err_d        = err_q;
        err_pend_d   = err_pend_q;
`endif
        case (estado_q)
            IDLE: begin
                if (start) begin
                    resto_d     = in_valor;
                    cnt_d       = '0;
                    valor_lat_d = in_valor;
                    estado_d    = RESTA;
`ifdef DEC_RANGO_CHK_EN
                    err_d       = 1'b0;
                    err_pend_d  = 1'b0;
                    // Out-of-range: zeroed operands fall straight through RESTA,
                    // keeping the 2-cycle done latency with zero results.
                    if (in_valor > ANCHO'(MAX_DOS_DIGITOS)) begin
                        resto_d     = '0;
                        valor_lat_d = '0;
                        err_pend_d  = 1'b1;
                    end
`endif
                end
            end
            RESTA: begin
                if (resto_q >= DIV_W) begin
                    resto_d = resto_menos;
                    cnt_d   = cnt_q + ANCHO'(1);
                end else begin
                    decenas_d    = cnt_q;
                    valor_orig_d = valor_lat_q;
                    estado_d     = FIN;
`ifdef DEC_RANGO_CHK_EN
                    err_d        = err_pend_q;
`endif
                end
            end
            FIN: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    assign busy       = (estado_q != IDLE);
    assign done       = (estado_q == FIN);
    assign decenas    = decenas_q;
    assign valor_orig = valor_orig_q;

endmodule

// File: tb/tb_extractor_decenas.sv
// Self-checking bench for extractor_decenas: directed cases plus randomized conversions.
module tb_extractor_decenas;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] in_valor;
    logic       busy;
    logic       done;
    logic [7:0] decenas;
    logic [7:0] valor_orig;
`ifdef DEC_RANGO_CHK_EN
    logic       err_rango;
`endif

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] prev_dec  = 8'd0;
    logic [7:0] prev_orig = 8'd0;

    always #5 clk = ~clk;

    extractor_decenas dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valor   (in_valor),
        .busy       (busy),
        .done       (done),
        .decenas    (decenas),
`ifdef DEC_RANGO_CHK_EN
        .err_rango  (err_rango),
`endif
        .valor_orig (valor_orig)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs one conversion from an IDLE negedge; inj>0 fires a stray start at that cycle.
    task automatic conv(input int v, input int inj, input bit rnd);
        int exp_dec, exp_orig, exp_lat, exp_err, lat;
        bit seen;
        exp_dec  = v / 10;
        exp_orig = v;
        exp_err  = 0;
`ifdef DEC_RANGO_CHK_EN
        if (v > 99) begin
            exp_dec  = 0;
            exp_orig = 0;
            exp_err  = 1;
        end
`endif
        exp_lat  = exp_dec + 2;
        start    = 1'b1;
        in_valor = v[7:0];
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                lat  = n;
            end else begin
                chk("hold_decenas", decenas, prev_dec);
                chk("hold_valor_orig", valor_orig, prev_orig);
                chk("busy_running", busy, 1);
                start = 1'b0;
                if (rnd) begin
                    start    = 1'($urandom_range(0, 1));
                    in_valor = 8'($urandom);
                end
                if (n == inj) begin
                    start    = 1'b1;
                    in_valor = 8'd12;
                end
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("latency", lat, exp_lat);
            chk("decenas", decenas, exp_dec);
            chk("valor_orig", valor_orig, exp_orig);
            chk("unidades", int'(valor_orig) - 10 * int'(decenas), exp_orig % 10);
`ifdef DEC_RANGO_CHK_EN
            chk("err_rango", err_rango, exp_err);
`endif
            prev_dec  = exp_dec[7:0];
            prev_orig = exp_orig[7:0];
        end
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        chk("decenas_after", decenas, prev_dec);
        $display("conv v=%0d decenas=%0d valor_orig=%0d latency=%0d err=%0d", v, decenas, valor_orig, lat, exp_err);
    endtask

    initial begin
        int ndone, last_c, dones_after;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valor = 8'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_decenas", decenas, 0);
        chk("reset_valor_orig", valor_orig, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Sweep and boundaries
        conv(0, 0, 0);
        conv(9, 0, 0);
        conv(10, 0, 0);
        conv(57, 0, 0);
        conv(99, 0, 0);
        conv(255, 0, 0);
        // Start while busy is ignored
        conv(73, 3, 0);
        // Held outputs across a conversion
        conv(42, 0, 0);
        conv(95, 0, 0);

        // Reset mid-conversion
        start    = 1'b1;
        in_valor = 8'd87;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_decenas", decenas, 0);
        chk("midrst_valor_orig", valor_orig, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones_after = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) dones_after++;
        end
        chk("midrst_no_done", dones_after, 0);
        chk("midrst_idle", busy, 0);
        $display("reset mid-conversion v=87 dones_after=%0d", dones_after);
        prev_dec  = 8'd0;
        prev_orig = 8'd0;

        // Randomized conversions with noise on start/in_valor while busy
        for (int i = 0; i < 25; i++) begin
            conv(int'($urandom_range(0, 255)), 0, 1);
        end

        // Back-to-back with start held high
        start    = 1'b1;
        in_valor = 8'd20;
        ndone    = 0;
        last_c   = 0;
        for (int c = 1; c <= 40 && ndone < 4; c++) begin
            @(negedge clk);
            if (done) begin
                if (ndone == 0) chk("b2b_first_latency", c, 4);
                else chk("b2b_period", c - last_c, 5);
                chk("b2b_decenas", decenas, 2);
                $display("b2b done at cycle %0d decenas=%0d", c, decenas);
                last_c = c;
                ndone++;
            end
        end
        chk("b2b_count", ndone, 4);
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
